dmem_req_queue: RTL
===================

DMEM_REQ_QUEUE -- requirements
Module: dmem_req_queue

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data bus width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter DEPTH, default 2, SHALL set the maximum number of outstanding (addr_ok'd, not yet data_ok'd) requests; legal range is 1..8.
REQ-004 Parameter TAG_W, default 5, SHALL set the width of the opaque tag carried from request to response (destination register number).
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port flush, input, 1 bit: pipeline cancel from an exception or ertn in a later stage.
REQ-008 Upstream request ports SHALL be: in_valid (in, 1); in_ready (out, 1); in_wr (in, 1); in_size (in, 2: 0=1B, 1=2B, 2=4B, 3=8B); in_signed (in, 1); in_addr (in, ADDR_W); in_wdata (in, DATA_W); in_tag (in, TAG_W).
REQ-009 Port in_ale, output, 1 bit: combinational misalignment flag for the current in_* request.
REQ-010 SRAM-side ports SHALL be: sram_req, sram_wr (out, 1); sram_size (out, 2); sram_wstrb (out, DATA_W/8); sram_addr (out, ADDR_W); sram_wdata (out, DATA_W); sram_addr_ok, sram_data_ok (in, 1); sram_rdata (in, DATA_W).
REQ-011 Response ports SHALL be: rsp_valid (out, 1); rsp_data (out, DATA_W, extended load data, 0 for stores); rsp_tag (out, TAG_W); rsp_is_store (out, 1).
REQ-012 Port busy, output, 1 bit: high while any request is held or outstanding.

Function
REQ-013 in_ale SHALL be 1 when in_addr is not a multiple of (1<<in_size); size 3 with DATA_W=32 also SHALL assert in_ale.
REQ-014 in_ready SHALL equal (state==IDLE) && (count<DEPTH) && !flush.
REQ-015 A request with in_valid && in_ready && !in_ale SHALL be latched into the hold register, and the FSM SHALL move IDLE->REQ.
REQ-016 A request with in_ale=1 SHALL be consumed and never issued to SRAM.
REQ-017 sram_req SHALL be registered: it rises the cycle after acceptance and equals (state==REQ).
REQ-018 While in REQ, all sram_* request outputs SHALL hold stable until the cycle sram_addr_ok=1, including across a flush.
REQ-019 On sram_addr_ok in REQ, the FSM SHALL return to IDLE and push {wr, size, signed, addr low bits, tag, discard} into the pending FIFO.
REQ-020 sram_wstrb SHALL select bytes addr[log2(DATA_W/8)-1:0] .. +(1<<size)-1, and SHALL be all-zero for loads.
REQ-021 sram_wdata SHALL replicate the low (8<<size) bits of in_wdata across the bus.
REQ-022 The outstanding count SHALL increment on a FIFO push and decrement on sram_data_ok; when both occur in the same cycle, count SHALL remain unchanged.
REQ-023 On sram_data_ok, the FIFO head SHALL pop.
REQ-024 When the popped entry's discard bit is 0, the same cycle SHALL drive rsp_valid=1 with rsp_tag and rsp_is_store from the entry.
REQ-025 For a load response, rsp_data SHALL be the selected byte, half, word or dword of sram_rdata, sign- or zero-extended per signed.
REQ-026 flush SHALL set discard in every FIFO entry and in the hold register; discarded responses SHALL be consumed silently.
REQ-027 A flush asserted in the same cycle as a push SHALL mark the pushed entry discarded.
REQ-028 A sram_data_ok arriving while count==0 SHALL be ignored, with the count saturating at 0.
REQ-029 busy SHALL equal (state==REQ) || (count!=0).

Reset
REQ-030 While resetn=0: state=IDLE, count=0, FIFO pointers=0, and sram_req=0, rsp_valid=0, busy=0, in_ready=0.
REQ-031 On reset release, in_ready SHALL become 1 on the first cycle.
REQ-032 Reset asserted mid-transaction SHALL drop sram_req immediately and abandon all outstanding entries.

Verification
REQ-033 Store-byte check: DATA_W=32, sb with addr 0x1003 and wdata 0xAB -> next cycle sram_req=1, wstrb=4'b1000, wdata=0xABABABAB; addr_ok then data_ok -> rsp_valid=1, rsp_is_store=1.
REQ-034 Signed-byte load check: ld.b at 0x2001 with rdata 0x0000_8000 -> rsp_data=0xFFFFFF80; ld.bu at the same address -> rsp_data=0x00000080.
REQ-035 Misalignment check: ld.w at 0x3002 -> in_ale=1, no sram_req, count stays 0.
REQ-036 Depth-limit check: with DEPTH=2, two loads addr_ok'd without data_ok -> in_ready=0; one data_ok -> in_ready=1 the next cycle; simultaneous addr_ok+data_ok -> count unchanged.
REQ-037 Flush check: flush with 2 outstanding and 1 held -> held request still completes its addr_ok handshake; all 3 data_ok produce rsp_valid=0; count ends at 0.
REQ-038 Reset-abort check: resetn=0 while sram_req=1 -> sram_req=0 asynchronously, busy=0.

Source files
------------

// File: rtl/dmem_req_queue_if.sv
// Bus bundle for dmem_req_queue: upstream request, SRAM-side handshake, response and busy.
interface dmem_req_queue_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TAG_W  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_wr;
    logic [1:0]            in_size;
    logic                  in_signed;
    logic [ADDR_W-1:0]     in_addr;
    logic [DATA_W-1:0]     in_wdata;
    logic [TAG_W-1:0]      in_tag;
    logic                  in_ale;

    logic                  sram_req;
    logic                  sram_wr;
    logic [1:0]            sram_size;
    logic [DATA_W/8-1:0]   sram_wstrb;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_W-1:0]     sram_wdata;
    logic                  sram_addr_ok;
    logic                  sram_data_ok;
    logic [DATA_W-1:0]     sram_rdata;

    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic [TAG_W-1:0]      rsp_tag;
    logic                  rsp_is_store;
    logic                  busy;

    // Queue side
    modport slave (
        input  in_valid, in_wr, in_size, in_signed, in_addr, in_wdata, in_tag,
        input  sram_addr_ok, sram_data_ok, sram_rdata,
        output in_ready, in_ale,
        output sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata,
        output rsp_valid, rsp_data, rsp_tag, rsp_is_store, busy
    );

    // Pipeline / SRAM environment side
    modport master (
        output in_valid, in_wr, in_size, in_signed, in_addr, in_wdata, in_tag,
        output sram_addr_ok, sram_data_ok, sram_rdata,
        input  in_ready, in_ale,
        input  sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata,
        input  rsp_valid, rsp_data, rsp_tag, rsp_is_store, busy
    );
endinterface

// File: rtl/dmem_req_queue.sv
// Data-memory request queue: one held request toward the SRAM, a FIFO of outstanding
// requests awaiting data_ok, load extension and flush-driven silent discard.
module dmem_req_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    dmem_req_queue_if.slave  bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, REQ} state_t;

    typedef struct packed {
        logic             wr;
        logic [1:0]       size;
        logic             sgn;
        logic [OFF_W-1:0] off;
        logic [TAG_W-1:0] tag;
    } ent_t;

    state_t             state;
    ent_t               hold;
    logic               hold_disc;
    logic [ADDR_W-1:0]  hold_addr;
    logic [DATA_W-1:0]  hold_wdata;
    logic [NB-1:0]      hold_wstrb;

    ent_t               fifo [DEPTH];
    logic [DEPTH-1:0]   disc;
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   count;

    logic [2:0]         amask;
    logic               accept;
    logic               push;
    logic               pop;
    logic [NB-1:0]      strb_c;
    logic [DATA_W-1:0]  wdata_c;
    ent_t               head;
    logic [DATA_W-1:0]  shifted;
    logic [DATA_W-1:0]  load_c;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Alignment mask for the incoming access size
    always_comb begin
        amask = 3'b111;
        case (bus.in_size)
            2'd0:    amask = 3'b000;
            2'd1:    amask = 3'b001;
            2'd2:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
    end

    assign bus.in_ale   = (|(bus.in_addr[2:0] & amask)) || ((bus.in_size == 2'd3) && (DATA_W == 32));
    assign bus.in_ready = resetn && (state == IDLE) && (count < CNT_W'(DEPTH)) && !flush;
    assign accept       = bus.in_valid && bus.in_ready && !bus.in_ale;
    assign push         = (state == REQ) && bus.sram_addr_ok;
    assign pop          = bus.sram_data_ok && (count != '0);

    // Byte strobes and replicated store data for the incoming request
    always_comb begin
        int unsigned nbytes;
        int unsigned off;
        nbytes  = 32'd1 << bus.in_size;
        if (nbytes > NB) nbytes = NB;
        off     = 32'(bus.in_addr[OFF_W-1:0]);
        strb_c  = '0;
        wdata_c = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            strb_c[b]          = bus.in_wr && (b >= off) && (b < off + nbytes);
            wdata_c[b*8 +: 8]  = bus.in_wdata[(b % nbytes)*8 +: 8];
        end
    end

    // Load data alignment and sign/zero extension from the FIFO head
    always_comb begin
        int unsigned nbits;
        logic        ext;
        head    = fifo[rptr];
        shifted = bus.sram_rdata >> {head.off, 3'b000};
        nbits   = 32'd8 << head.size;
        if (nbits > DATA_W) nbits = DATA_W;
        ext     = head.sgn && shifted[IDX_W'(nbits - 1)];
        load_c  = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            load_c[i] = (i < nbits) ? shifted[i] : ext;
        end
    end

    assign bus.sram_req     = (state == REQ);
    assign bus.sram_wr      = hold.wr;
    assign bus.sram_size    = hold.size;
    assign bus.sram_wstrb   = hold_wstrb;
    assign bus.sram_addr    = hold_addr;
    assign bus.sram_wdata   = hold_wdata;

    assign bus.rsp_valid    = pop && !disc[rptr];
    assign bus.rsp_data     = head.wr ? '0 : load_c;
    assign bus.rsp_tag      = head.tag;
    assign bus.rsp_is_store = head.wr;
    assign bus.busy         = (state == REQ) || (count != '0);

    // FSM, hold register and pending FIFO
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            hold       <= '0;
            hold_disc  <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_wstrb <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
            disc       <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold.wr    <= bus.in_wr;
                        hold.size  <= bus.in_size;
                        hold.sgn   <= bus.in_signed;
                        hold.off   <= bus.in_addr[OFF_W-1:0];
                        hold.tag   <= bus.in_tag;
                        hold_disc  <= 1'b0;
                        hold_addr  <= bus.in_addr;
                        hold_wdata <= wdata_c;
                        hold_wstrb <= strb_c;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (flush)            hold_disc <= 1'b1;
                    if (bus.sram_addr_ok) state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (flush) disc <= '1;
            if (push) begin
                fifo[wptr] <= hold;
                disc[wptr] <= hold_disc || flush;
                wptr       <= ptr_next(wptr);
            end
            if (pop) rptr <= ptr_next(rptr);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
